bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: BCD_COUNTDOWN_TIMER

---
 rtl/bcd_countdown_timer_pkg.sv | 19 +
 rtl/bcd_countdown_timer_digit_down.sv | 26 ++
 rtl/bcd_countdown_timer.sv | 165 ++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// BCD digit width and the preset digit clamp helper.
package bcd_countdown_timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  // A preset nibble above 9 is not a decimal digit; saturate it to 9.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD digit of the down-counter: subtracts borrow_in, wraps 0 -> 9
// and raises borrow_out when it wraps.
module bcd_countdown_timer_digit_down
  import bcd_countdown_timer_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_out,
  output logic             borrow_out
);

  // Single-digit BCD subtract-with-borrow.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == '0) begin
        digit_out  = 4'd9;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer with prescaler and IDLE/RUN/PAUSE/EXPIRED FSM.
// Optional feature: define BCD_TIMER_AUTO_RELOAD_EN to reload the last
// loaded value on expiry and keep running (ALARM then stays low).
// LOAD, START and STOP are single-cycle strobes sampled only while CE is
// high; when several coincide LOAD wins over STOP, and STOP over START.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10000000,
  parameter int PSC_BITS = 27
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    CE,
  input  logic                    LOAD,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [BCD_W*DIGITS-1:0] PRESET,
  output logic [BCD_W*DIGITS-1:0] COUNT,
  output logic                    RUNNING,
  output logic                    TICK,
  output logic                    DONE,
  output logic                    ALARM,
  output state_t                  fsm_state
);

  localparam int CW = BCD_W * DIGITS;
  localparam logic [PSC_BITS-1:0] PSC_TOP = PSC_BITS'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PSC_BITS-1:0] psc_q, psc_d;
  logic                done_q, done_d;
  logic                tick;
  logic [CW-1:0]       preset_clamped;
  logic [CW-1:0]       count_dec;
  logic [DIGITS:0]     borrow;
  logic                dec_zero;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [CW-1:0]       shadow_q, shadow_d;
`endif

  // Saturate every preset digit to a legal decimal digit.
  always_comb begin
    preset_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      preset_clamped[i*BCD_W +: BCD_W] = clamp_digit(PRESET[i*BCD_W +: BCD_W]);
    end
  end

  // Ripple-borrow chain computing COUNT - 1 in BCD.
  assign borrow[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_countdown_timer_digit_down u_digit (
      .digit_in  (count_q[g*BCD_W +: BCD_W]),
      .borrow_in (borrow[g]),
      .digit_out (count_dec[g*BCD_W +: BCD_W]),
      .borrow_out(borrow[g+1])
    );
  end

  // A borrow out of the top digit means COUNT was already zero; treat it
  // as an expiry rather than wrapping to all nines.
  assign dec_zero = (count_dec == '0) || borrow[DIGITS];

  // State, count, prescaler and done-pulse registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      psc_q    <= '0;
      done_q   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      shadow_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      psc_q    <= psc_d;
      done_q   <= done_d;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  // Next-state logic. A "cleared" prescaler restarts a full tick period,
  // so it is loaded with TICK_DIV-1. The decrement is committed on the
  // edge that ends the TICK cycle, so COUNT shows it one cycle later.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    psc_d    = psc_q;
    done_d   = 1'b0;
    tick     = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    shadow_d = shadow_q;
`endif
    if (CE) begin
      if (LOAD) begin
        state_d  = S_IDLE;
        count_d  = preset_clamped;
        psc_d    = PSC_TOP;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        shadow_d = preset_clamped;
`endif
      end else begin
        unique case (state_q)
          S_IDLE, S_PAUSE: begin
            if (START && !STOP) begin
              if (count_q == '0) begin
                state_d = S_EXPIRED;
                done_d  = 1'b1;
              end else begin
                state_d = S_RUN;
                // Resuming from PAUSE keeps the partial tick period.
                if (state_q == S_IDLE) psc_d = PSC_TOP;
              end
            end
          end
          S_RUN: begin
            if (STOP) begin
              state_d = S_PAUSE;
            end else if (psc_q == '0) begin
              tick  = 1'b1;
              psc_d = PSC_TOP;
              if (dec_zero) begin
                done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                count_d = shadow_q;
`else
                count_d = '0;
                state_d = S_EXPIRED;
`endif
              end else begin
                count_d = count_dec;
              end
            end else begin
              psc_d = psc_q - PSC_BITS'(1);
            end
          end
          S_EXPIRED: begin
            count_d = '0;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  assign COUNT     = count_q;
  assign RUNNING   = (state_q == S_RUN);
  assign TICK      = tick;
  assign DONE      = done_q & CE;
  assign fsm_state = state_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  assign ALARM     = 1'b0;
`else
  assign ALARM     = (state_q == S_EXPIRED);
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed testbench for bcd_countdown_timer (DIGITS=4, TICK_DIV=4) with
// an integer-valued reference model checked on every falling clock edge.
// Define BCD_TIMER_AUTO_RELOAD_EN to exercise the auto-reload build.
module tb_bcd_countdown_timer;
  import bcd_countdown_timer_pkg::*;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXPIRED = 3;

  logic        CLK, CLR, CE, LOAD, START, STOP;
  logic [15:0] PRESET, COUNT;
  logic        RUNNING, TICK, DONE, ALARM;
  state_t      dut_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  bcd_countdown_timer #(
    .DIGITS  (DIGITS),
    .TICK_DIV(TICK_DIV),
    .PSC_BITS(2)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .CE       (CE),
    .LOAD     (LOAD),
    .START    (START),
    .STOP     (STOP),
    .PRESET   (PRESET),
    .COUNT    (COUNT),
    .RUNNING  (RUNNING),
    .TICK     (TICK),
    .DONE     (DONE),
    .ALARM    (ALARM),
    .fsm_state(dut_state)
  );

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int preset_value(input logic [15:0] p);
    int v = 0;
    int scale = 1;
    int d;
    for (int i = 0; i < 4; i++) begin
      d = int'(p[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * scale;
      scale *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] r = '0;
    int v = value;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  int m_state  = M_IDLE;
  int m_count  = 0;
  int m_psc    = 0;
  int m_shadow = 0;
  bit m_done   = 1'b0;

  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      m_state = M_IDLE;
      m_count = 0;
      m_psc   = 0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (CE) begin
        if (LOAD) begin
          m_count  = preset_value(PRESET);
          m_shadow = m_count;
          m_state  = M_IDLE;
          m_psc    = TICK_DIV - 1;
        end else if (m_state == M_RUN) begin
          if (STOP) begin
            m_state = M_PAUSE;
          end else if (m_psc == 0) begin
            m_psc   = TICK_DIV - 1;
            m_count = m_count - 1;
            if (m_count == 0) begin
              m_done = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
              m_count = m_shadow;
`else
              m_state = M_EXPIRED;
`endif
            end
          end else begin
            m_psc = m_psc - 1;
          end
        end else if ((m_state == M_IDLE || m_state == M_PAUSE) && START && !STOP) begin
          if (m_count == 0) begin
            m_state = M_EXPIRED;
            m_done  = 1'b1;
          end else begin
            if (m_state == M_IDLE) m_psc = TICK_DIV - 1;
            m_state = M_RUN;
          end
        end
      end
    end
  end

  // Scoreboard compare: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    chk("cmp_count",   32'(COUNT),   32'(to_bcd(m_count)));
    chk("cmp_running", 32'(RUNNING), 32'(m_state == M_RUN));
    chk("cmp_tick",    32'(TICK),
        32'(CE && m_state == M_RUN && m_psc == 0 && !LOAD && !STOP));
    chk("cmp_done",    32'(DONE),    32'(m_done && CE));
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    chk("cmp_alarm",   32'(ALARM),   32'd0);
`else
    chk("cmp_alarm",   32'(ALARM),   32'(m_state == M_EXPIRED));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
    LOAD  = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] pre);
    PRESET = pre;
    LOAD   = 1'b1;
    next_cycle();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    next_cycle();
  endtask

  logic [15:0] pre_tbl [4] = '{16'h1234, 16'hF0A9, 16'hB7C0, 16'h0000};
  logic [15:0] exp_tbl [4] = '{16'h1234, 16'h9099, 16'h9790, 16'h0000};

  // ---------------- directed stimulus ----------------
  initial begin
    CLR = 1'b0; CE = 1'b1; LOAD = 1'b0; START = 1'b0; STOP = 1'b0; PRESET = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_count",   32'(COUNT),   32'h0);
    chk("reset_running", 32'(RUNNING), 32'h0);
    chk("reset_tick",    32'(TICK),    32'h0);
    chk("reset_done",    32'(DONE),    32'h0);
    chk("reset_alarm",   32'(ALARM),   32'h0);
    CLR = 1'b1;
    next_cycle();

    // Load with digit clamping.
    for (int i = 0; i < 4; i++) begin
      pulse_load(pre_tbl[i]);
      chk("load_clamp", 32'(COUNT), 32'(exp_tbl[i]));
    end

    // Borrow across digits: 1000 -> 0999 after one tick.
    pulse_load(16'h1000);
    pulse_start();
    chk("run_after_start", 32'(RUNNING), 32'h1);
    repeat (3) next_cycle();
    chk("first_tick", 32'(TICK), 32'h1);
    chk("count_at_tick", 32'(COUNT), 32'h1000);
    next_cycle();
    chk("borrow_0999", 32'(COUNT), 32'h0999);

    // Pause with prescaler at 2, resume keeps the partial period.
    next_cycle();
    STOP = 1'b1;
    next_cycle();
    chk("pause_running", 32'(RUNNING), 32'h0);
    chk("pause_state", 32'(dut_state), 32'(S_PAUSE));
    repeat (20) next_cycle();
    chk("pause_count_held", 32'(COUNT), 32'h0999);
    START = 1'b1;
    next_cycle();
    chk("resume_c1_tick", 32'(TICK), 32'h0);
    next_cycle();
    chk("resume_c2_tick", 32'(TICK), 32'h0);
    next_cycle();
    chk("resume_c3_tick", 32'(TICK), 32'h1);
    chk("resume_c3_count", 32'(COUNT), 32'h0999);
    next_cycle();
    chk("resume_dec", 32'(COUNT), 32'h0998);

    // All three strobes together: LOAD wins.
    PRESET = 16'h00A5; LOAD = 1'b1; STOP = 1'b1; START = 1'b1;
    next_cycle();
    chk("prio_count", 32'(COUNT), 32'h0095);
    chk("prio_state", 32'(dut_state), 32'(S_IDLE));
    repeat (5) next_cycle();
    chk("idle_hold_count", 32'(COUNT), 32'h0095);

    // Clock enable freezes everything, including TICK.
    pulse_start();
    repeat (3) next_cycle();
    chk("ce_tick_before", 32'(TICK), 32'h1);
    CE = 1'b0;
    #1;
    chk("ce_tick_low", 32'(TICK), 32'h0);
    repeat (10) next_cycle();
    chk("ce_count_held", 32'(COUNT), 32'h0095);
    chk("ce_running_held", 32'(RUNNING), 32'h1);
    CE = 1'b1;
    #1;
    chk("ce_tick_again", 32'(TICK), 32'h1);
    next_cycle();
    chk("ce_dec", 32'(COUNT), 32'h0094);

    // Asynchronous reset mid-run, then START with a zero count.
    repeat (2) next_cycle();
    #2;
    CLR = 1'b0;
    #1;
    chk("async_count",   32'(COUNT),   32'h0);
    chk("async_running", 32'(RUNNING), 32'h0);
    chk("async_tick",    32'(TICK),    32'h0);
    chk("async_done",    32'(DONE),    32'h0);
    chk("async_alarm",   32'(ALARM),   32'h0);
    next_cycle();
    CLR = 1'b1;
    next_cycle();
    chk("post_reset_state", 32'(dut_state), 32'(S_IDLE));
    pulse_start();
    chk("start_zero_done", 32'(DONE), 32'h1);
    chk("start_zero_running", 32'(RUNNING), 32'h0);
    next_cycle();
    chk("start_zero_done_off", 32'(DONE), 32'h0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    begin
      int n;
      pulse_load(16'h0002);
      pulse_start();
      n = 0;
      while (DONE !== 1'b1 && n < 30) begin
        next_cycle();
        n++;
      end
      chk("auto_first_done", 32'(n), 32'd8);
      chk("auto_reload_count", 32'(COUNT), 32'h0002);
      chk("auto_running", 32'(RUNNING), 32'h1);
      for (int k = 0; k < 2; k++) begin
        next_cycle();
        n = 1;
        while (DONE !== 1'b1 && n < 30) begin
          next_cycle();
          n++;
        end
        chk("auto_done_period", 32'(n), 32'd8);
        chk("auto_alarm", 32'(ALARM), 32'h0);
      end
    end
`else
    // Full countdown 0003 -> 0000 with expiry.
    pulse_load(16'h0003);
    chk("exp_load_alarm", 32'(ALARM), 32'h0);
    pulse_start();
    repeat (3) next_cycle();
    chk("exp_tick1", 32'(TICK), 32'h1);
    next_cycle();
    chk("exp_count2", 32'(COUNT), 32'h0002);
    repeat (4) next_cycle();
    chk("exp_count1", 32'(COUNT), 32'h0001);
    repeat (4) next_cycle();
    chk("exp_count0", 32'(COUNT), 32'h0000);
    chk("exp_done", 32'(DONE), 32'h1);
    chk("exp_alarm", 32'(ALARM), 32'h1);
    chk("exp_running", 32'(RUNNING), 32'h0);
    next_cycle();
    chk("exp_done_off", 32'(DONE), 32'h0);
    chk("exp_alarm_held", 32'(ALARM), 32'h1);
    pulse_start();
    chk("exp_ignore_start", 32'(dut_state), 32'(S_EXPIRED));
    STOP = 1'b1;
    next_cycle();
    chk("exp_ignore_stop", 32'(ALARM), 32'h1);
    pulse_load(16'h0001);
    chk("exp_leave_alarm", 32'(ALARM), 32'h0);
    chk("exp_leave_count", 32'(COUNT), 32'h0001);
`endif

    repeat (2) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
